// File: rtl/tl_inflight_monitor.sv
// Passive TileLink-UL/UH A/D monitor: tracks outstanding sources, counts burst beats, flags protocol violations.
// Latency: violations appear in err_sticky/err_pulse one clock after detection; inflight_cnt is registered.
// Backpressure: none exerted; purely observes valid/ready on both channels and never drives the bus.
//
// Ports:
//   clock, reset              - sole clock, synchronous active-high reset
//   a_valid/a_ready/a_*       - observed A channel handshake and header fields
//   d_valid/d_ready/d_*       - observed D channel handshake and header fields
//   clear_err                 - clears err_sticky (a same-cycle detection still sets its bit)
//   err_sticky[7:0]           - latched violation flags:
//                               [0] A stall  [1] A burst header  [2] A source reuse
//                               [3] D stall  [4] D unexpected    [5] D size  [6] D opcode  [7] watchdog
//   err_pulse                 - one-cycle pulse after any new detection
//   inflight_cnt              - number of sources currently outstanding
//
// Optional: define TL_INFLIGHT_MON_WATCHDOG_EN to build the response-latency watchdog (err_sticky[7]);
// without it err_sticky[7] is constant 0.

module tl_inflight_monitor #(
  parameter int SOURCE_BITS    = 7,
  parameter int SIZE_BITS      = 3,
  parameter int ADDR_BITS      = 32,
  parameter int BEAT_LOG2      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   clear_err,
  output logic [7:0]             err_sticky,
  output logic                   err_pulse,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int NSRC   = 2 ** SOURCE_BITS;
  // Wide enough to hold the largest burst length 2^(2^SIZE_BITS-1).
  localparam int BCNT_W = 2 ** SIZE_BITS;
  localparam logic [SIZE_BITS-1:0] BEAT_SZ = SIZE_BITS'(BEAT_LOG2);

  typedef logic [BCNT_W-1:0] bcnt_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
  } a_hdr_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
  } d_hdr_t;

  function automatic bcnt_t burst_beats(input logic has_data, input logic [SIZE_BITS-1:0] size);
    bcnt_t b;
    b = bcnt_t'(1);
    if (has_data && (size > BEAT_SZ)) begin
      b = bcnt_t'(1) << (size - BEAT_SZ);
    end
    return b;
  endfunction

  // D opcode a well-behaved slave must answer with, given the tracked A opcode.
  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_op);
    logic [2:0] r;
    case (a_op)
      3'd0, 3'd1:       r = 3'd0;  // Put -> AccessAck
      3'd2, 3'd3, 3'd4: r = 3'd1;  // Arith/Logic/Get -> AccessAckData
      3'd5:             r = 3'd2;  // Hint -> HintAck
      default:          r = 3'd0;  // untracked opcodes never reach the table
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bcnt_t                  a_cnt_q, a_cnt_d;
  bcnt_t                  d_cnt_q, d_cnt_d;
  a_hdr_t                 a_hdr_q, a_hdr_d;
  logic [2:0]             d_hop_q, d_hop_d;
  logic [SIZE_BITS-1:0]   d_hsz_q, d_hsz_d;
  logic                   a_stall_q;
  a_hdr_t                 a_pay_q;
  logic                   d_stall_q;
  d_hdr_t                 d_pay_q;
  logic [NSRC-1:0]        inflight_q, inflight_d;
  logic [SOURCE_BITS:0]   cnt_q, cnt_d;
  logic [7:0]             sticky_q, sticky_d;
  logic                   pulse_q;
  logic [SIZE_BITS-1:0]   req_size_q   [NSRC];
  logic [2:0]             req_opcode_q [NSRC];

  // ---------------------------------------------------------------------------
  // Channel decode
  // ---------------------------------------------------------------------------
  logic   a_fire, d_fire, a_first, d_first, a_legal, a_set, d_last, d_clr;
  a_hdr_t a_cur;
  d_hdr_t d_cur;
  bcnt_t  a_beats_now, a_beats_hdr, d_beats_now, d_beats_hdr;

  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_cur   = {a_opcode, a_param, a_size, a_source, a_address};
  assign d_cur   = {d_opcode, d_size, d_source};
  assign a_first = (a_cnt_q == '0);
  assign d_first = (d_cnt_q == '0);
  // Opcodes 6/7 are not TileLink-UL/UH A messages; they are passed over silently.
  assign a_legal = ~(a_opcode[2] & a_opcode[1]);
  assign a_set   = a_fire & a_first & a_legal;

  // A opcodes 0..3 carry data; D opcode 1 (AccessAckData) carries data.
  assign a_beats_now = burst_beats(~a_opcode[2], a_size);
  assign a_beats_hdr = burst_beats(~a_hdr_q.opcode[2], a_hdr_q.size);
  assign d_beats_now = burst_beats(d_opcode == 3'd1, d_size);
  assign d_beats_hdr = burst_beats(d_hop_q == 3'd1, d_hsz_q);

  assign d_last = d_first ? (d_beats_now == bcnt_t'(1)) : (d_cnt_q == d_beats_hdr - bcnt_t'(1));
  assign d_clr  = d_fire & d_last;

  // Beat counters and burst header capture.
  always_comb begin
    a_cnt_d = a_cnt_q;
    a_hdr_d = a_hdr_q;
    if (a_fire) begin
      if (a_first) begin
        a_hdr_d = a_cur;
        a_cnt_d = (a_beats_now == bcnt_t'(1)) ? '0 : bcnt_t'(1);
      end else if (a_cnt_q == a_beats_hdr - bcnt_t'(1)) begin
        a_cnt_d = '0;
      end else begin
        a_cnt_d = a_cnt_q + bcnt_t'(1);
      end
    end
  end

  always_comb begin
    d_cnt_d = d_cnt_q;
    d_hop_d = d_hop_q;
    d_hsz_d = d_hsz_q;
    if (d_fire) begin
      if (d_first) begin
        d_hop_d = d_opcode;
        d_hsz_d = d_size;
        d_cnt_d = (d_beats_now == bcnt_t'(1)) ? '0 : bcnt_t'(1);
      end else if (d_last) begin
        d_cnt_d = '0;
      end else begin
        d_cnt_d = d_cnt_q + bcnt_t'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source tracking
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] set_vec, clr_vec;
  logic            cnt_inc, cnt_dec;

  always_comb begin
    set_vec    = a_set ? (NSRC'(1) << a_source) : '0;
    clr_vec    = d_clr ? (NSRC'(1) << d_source) : '0;
    // A set on the same source as a D retire wins.
    inflight_d = (inflight_q & ~clr_vec) | set_vec;
    // Count real 0->1 and 1->0 transitions so inflight_cnt always equals the popcount.
    cnt_inc    = a_set & ~inflight_q[a_source];
    cnt_dec    = d_clr & inflight_q[d_source] & ~(a_set & (a_source == d_source));
    cnt_d      = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  logic wd_hit;

`ifdef TL_INFLIGHT_MON_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;

  // Saturating at WD_MAX makes the flag fire once per stalled episode.
  always_comb begin
    wd_d   = wd_q;
    wd_hit = 1'b0;
    if (d_fire || (cnt_q == '0)) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d   = wd_q + WD_W'(1);
      wd_hit = (wd_q == WD_MAX - WD_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Violation detection
  // ---------------------------------------------------------------------------
  logic [7:0] det;
  logic       d_chk, d_known;

  always_comb begin
    det     = '0;
    d_chk   = d_fire & d_first;
    d_known = inflight_q[d_source];
    det[0]  = a_stall_q & (~a_valid | (a_cur != a_pay_q));
    // Address is part of the burst header; every beat must repeat it.
    det[1]  = a_fire & ~a_first & (a_cur != a_hdr_q);
    det[2]  = a_set & inflight_q[a_source];
    det[3]  = d_stall_q & (~d_valid | (d_cur != d_pay_q));
    det[4]  = d_chk & ~d_known;
    det[5]  = d_chk & d_known & (d_size != req_size_q[d_source]);
    det[6]  = d_chk & d_known & (d_opcode != exp_d_opcode(req_opcode_q[d_source]));
    det[7]  = wd_hit;
    sticky_d = (sticky_q & ~{8{clear_err}}) | det;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt_q    <= '0;
      d_cnt_q    <= '0;
      a_hdr_q    <= '0;
      d_hop_q    <= '0;
      d_hsz_q    <= '0;
      a_stall_q  <= 1'b0;
      a_pay_q    <= '0;
      d_stall_q  <= 1'b0;
      d_pay_q    <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      sticky_q   <= '0;
      pulse_q    <= 1'b0;
    end else begin
      a_cnt_q    <= a_cnt_d;
      d_cnt_q    <= d_cnt_d;
      a_hdr_q    <= a_hdr_d;
      d_hop_q    <= d_hop_d;
      d_hsz_q    <= d_hsz_d;
      a_stall_q  <= a_valid & ~a_ready;
      a_pay_q    <= a_cur;
      d_stall_q  <= d_valid & ~d_ready;
      d_pay_q    <= d_cur;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      pulse_q    <= |det;
    end
  end

  // Request attributes only matter while the source is inflight, so no reset is needed.
  always_ff @(posedge clock) begin
    if (a_set) begin
      req_size_q[a_source]   <= a_size;
      req_opcode_q[a_source] <= a_opcode;
    end
  end

  assign err_sticky   = sticky_q;
  assign err_pulse    = pulse_q;
  assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_tl_inflight_monitor.sv
module tb_tl_inflight_monitor;

  localparam int SB = 7;
  localparam int ZB = 3;
  localparam int AB = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode, a_param;
  logic [ZB-1:0] a_size;
  logic [SB-1:0] a_source;
  logic [AB-1:0] a_address;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [ZB-1:0] d_size;
  logic [SB-1:0] d_source;
  logic          clear_err;
  logic [7:0]    err_sticky;
  logic          err_pulse;
  logic [SB:0]   inflight_cnt;

  always #5 clock = ~clock;

  tl_inflight_monitor #(
    .SOURCE_BITS(SB), .SIZE_BITS(ZB), .ADDR_BITS(AB), .BEAT_LOG2(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .clear_err(clear_err),
    .err_sticky(err_sticky), .err_pulse(err_pulse), .inflight_cnt(inflight_cnt)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] sticky;
    logic [7:0] cnt;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

`ifdef TL_INFLIGHT_MON_WATCHDOG_EN
  localparam logic [7:0] WD_BIT = 8'h80;
`else
  localparam logic [7:0] WD_BIT = 8'h00;
`endif

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: compares every expectation due by this cycle, on the falling edge.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if (mon_e.cyc != cyc || err_sticky !== mon_e.sticky || inflight_cnt !== mon_e.cnt ||
          err_pulse !== mon_e.pulse) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got sticky=%h cnt=%0d pulse=%b, want sticky=%h cnt=%0d pulse=%b",
                 mon_e.name, cyc, err_sticky, inflight_cnt, err_pulse,
                 mon_e.sticky, mon_e.cnt, mon_e.pulse);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    a_ready   = 1'b1;
    d_valid   = 1'b0;
    d_ready   = 1'b1;
    clear_err = 1'b0;
  endtask

  task automatic drv_a(input logic [2:0] op, input logic [2:0] prm, input logic [ZB-1:0] sz,
                       input logic [SB-1:0] src, input logic [AB-1:0] addr, input logic rdy);
    a_valid   = 1'b1;
    a_ready   = rdy;
    a_opcode  = op;
    a_param   = prm;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
  endtask

  task automatic drv_d(input logic [2:0] op, input logic [ZB-1:0] sz, input logic [SB-1:0] src,
                       input logic rdy);
    d_valid  = 1'b1;
    d_ready  = rdy;
    d_opcode = op;
    d_size   = sz;
    d_source = src;
  endtask

  task automatic chk_at(input string name, input int at, input logic [7:0] s,
                        input logic [7:0] c, input logic p);
    exp_t e;
    e.name   = name;
    e.cyc    = at;
    e.sticky = s;
    e.cnt    = c;
    e.pulse  = p;
    exp_q.push_back(e);
  endtask

  // Expected state after the next active edge samples the inputs just driven.
  task automatic chk(input string name, input logic [7:0] s, input logic [7:0] c, input logic p);
    chk_at(name, cyc + 1, s, c, p);
  endtask

  task automatic do_reset(input string name);
    idle();
    reset = 1'b1;
    chk(name, 8'h00, 8'd0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int c0;
    reset     = 1'b1;
    a_opcode  = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0;
    d_opcode  = '0; d_size  = '0; d_source = '0;
    idle();
    tick(); tick();

    // 1: Get src5 size3 -> single-beat AccessAckData
    do_reset("t1 reset");
    drv_a(3'd4, 3'd0, 3'd3, 7'd5, 32'h100, 1'b1); chk("t1 get", 8'h00, 8'd1, 1'b0); tick();
    idle(); drv_d(3'd1, 3'd3, 7'd5, 1'b1);         chk("t1 ackdata", 8'h00, 8'd0, 1'b0); tick();
    idle();                                        chk("t1 idle", 8'h00, 8'd0, 1'b0); tick();

    // 2: PutFull src2 size5 (4 beats), third beat changes address
    do_reset("t2 reset");
    for (int i = 0; i < 4; i++) begin
      drv_a(3'd0, 3'd0, 3'd5, 7'd2, (i == 2) ? 32'h208 : 32'h200, 1'b1);
      if (i < 2)       chk("t2 beat ok", 8'h00, 8'd1, 1'b0);
      else if (i == 2) chk("t2 beat bad", 8'h02, 8'd1, 1'b1);
      else             chk("t2 last beat", 8'h02, 8'd1, 1'b0);
      tick();
    end
    idle(); drv_d(3'd0, 3'd5, 7'd2, 1'b1); chk("t2 ack retires", 8'h02, 8'd0, 1'b0); tick();

    // 3: Two Gets on src9 with no response between
    do_reset("t3 reset");
    drv_a(3'd4, 3'd0, 3'd2, 7'd9, 32'h40, 1'b1); chk("t3 get1", 8'h00, 8'd1, 1'b0); tick();
    drv_a(3'd4, 3'd0, 3'd2, 7'd9, 32'h40, 1'b1); chk("t3 get2 reuse", 8'h04, 8'd1, 1'b1); tick();
    idle();                                       chk("t3 idle", 8'h04, 8'd1, 1'b0); tick();

    // 4: Unexpected D, then size/opcode mismatched response
    do_reset("t4 reset");
    drv_d(3'd0, 3'd0, 7'd3, 1'b1); chk("t4 unexpected d", 8'h10, 8'd0, 1'b1); tick();
    idle(); drv_a(3'd4, 3'd0, 3'd2, 7'd4, 32'h80, 1'b1); chk("t4 get", 8'h10, 8'd1, 1'b0); tick();
    idle(); drv_d(3'd0, 3'd3, 7'd4, 1'b1); chk("t4 bad resp", 8'h70, 8'd0, 1'b1); tick();
    idle();                                chk("t4 idle", 8'h70, 8'd0, 1'b0); tick();

    // 5: A stall with param change; then clear_err racing a D stall violation
    do_reset("t5 reset");
    drv_a(3'd4, 3'd0, 3'd2, 7'd6, 32'h80, 1'b0); chk("t5 stall1", 8'h00, 8'd0, 1'b0); tick();
    drv_a(3'd4, 3'd1, 3'd2, 7'd6, 32'h80, 1'b0); chk("t5 stall chg", 8'h01, 8'd0, 1'b1); tick();
    drv_a(3'd4, 3'd1, 3'd2, 7'd6, 32'h80, 1'b1); chk("t5 a fire", 8'h01, 8'd1, 1'b0); tick();
    idle(); drv_d(3'd1, 3'd2, 7'd6, 1'b0);       chk("t5 d stall", 8'h01, 8'd1, 1'b0); tick();
    idle(); clear_err = 1'b1;                    chk("t5 clr+dstall", 8'h08, 8'd1, 1'b1); tick();
    idle();                                      chk("t5 hold", 8'h08, 8'd1, 1'b0); tick();
    idle(); clear_err = 1'b1;                    chk("t5 clear", 8'h00, 8'd1, 1'b0); tick();
    idle(); drv_d(3'd1, 3'd2, 7'd6, 1'b1);       chk("t5 retire", 8'h00, 8'd0, 1'b0); tick();

    // 6: Watchdog on an unanswered Get src1
    do_reset("t6 reset");
    drv_a(3'd4, 3'd0, 3'd2, 7'd1, 32'h10, 1'b1);
    c0 = cyc;
    chk_at("t6 get", c0 + 1, 8'h00, 8'd1, 1'b0);
    chk_at("t6 before timeout", c0 + 16, 8'h00, 8'd1, 1'b0);
    chk_at("t6 timeout", c0 + 17, WD_BIT, 8'd1, (WD_BIT != 8'h00));
    chk_at("t6 once", c0 + 18, WD_BIT, 8'd1, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 40 && cyc < c0 + 19; k++) tick();
    drv_d(3'd1, 3'd2, 7'd1, 1'b1); chk("t6 late d", WD_BIT, 8'd0, 1'b0); tick();
    idle(); tick(); tick();        chk("t6 quiet", WD_BIT, 8'd0, 1'b0); tick();

    // 7: Reuse while the same source retires in the same cycle
    do_reset("t7 reset");
    drv_a(3'd4, 3'd0, 3'd2, 7'd7, 32'h20, 1'b1); chk("t7 get", 8'h00, 8'd1, 1'b0); tick();
    drv_a(3'd4, 3'd0, 3'd2, 7'd7, 32'h20, 1'b1);
    drv_d(3'd1, 3'd2, 7'd7, 1'b1);                chk("t7 set wins", 8'h04, 8'd1, 1'b1); tick();
    idle(); drv_d(3'd1, 3'd2, 7'd7, 1'b1);        chk("t7 retire", 8'h04, 8'd0, 1'b0); tick();

    // 8: Two-beat AccessAckData retires only on its last beat
    do_reset("t8 reset");
    drv_a(3'd4, 3'd0, 3'd4, 7'd10, 32'h300, 1'b1); chk("t8 get", 8'h00, 8'd1, 1'b0); tick();
    idle(); drv_d(3'd1, 3'd4, 7'd10, 1'b1);        chk("t8 d beat0", 8'h00, 8'd1, 1'b0); tick();
    drv_d(3'd1, 3'd4, 7'd10, 1'b1);                chk("t8 d beat1", 8'h00, 8'd0, 1'b0); tick();
    drv_d(3'd0, 3'd0, 7'd10, 1'b1);                chk("t8 stray d", 8'h10, 8'd0, 1'b1); tick();
    idle(); tick(); tick(); tick();

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
